// File: rtl/myproject_sdiv_pkg.sv
// Shared constants and types for the 20s/8s -> 12s sequential divider.
// Widths, latency, FSM state encoding and quotient saturation limits.
package myproject_sdiv_pkg;
    localparam int DIN0_W  = 20;
    localparam int DIN1_W  = 8;
    localparam int DOUT_W  = 12;
    localparam int REM_W   = 9;
    localparam int CNT_W   = 5;
    localparam int ITERS   = 20;
    localparam int LATENCY = 22;

    localparam logic signed [DOUT_W-1:0] Q_MAX = 12'sh7FF;
    localparam logic signed [DOUT_W-1:0] Q_MIN = 12'sh800;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;
endpackage

// File: rtl/myproject_sdiv_20s_8s_12_seq_if.sv
// Block-level control and operand/result bundle of the divider.
// master drives requests and operands; slave returns status and results.
interface myproject_sdiv_20s_8s_12_seq_if;
    import myproject_sdiv_pkg::*;

    logic                     ap_start;
    logic signed [DIN0_W-1:0] din0;
    logic signed [DIN1_W-1:0] din1;
    logic                     ap_idle;
    logic                     ap_ready;
    logic                     ap_done;
    logic signed [DOUT_W-1:0] dout;
    logic signed [DIN1_W-1:0] rem;
    logic                     ovf;
    logic                     dbz;

    modport master (
        output ap_start, din0, din1,
        input  ap_idle, ap_ready, ap_done, dout, rem, ovf, dbz
    );

    modport slave (
        input  ap_start, din0, din1,
        output ap_idle, ap_ready, ap_done, dout, rem, ovf, dbz
    );
endinterface

// File: rtl/myproject_sdiv_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
// Remainder stays below the divisor, so the shifted value fits 10 bits.
module myproject_sdiv_step
    import myproject_sdiv_pkg::*;
(
    input  logic [REM_W-1:0]  i_rem,
    input  logic [DIN1_W-1:0] i_div,
    input  logic              i_bit,
    output logic [REM_W-1:0]  o_rem,
    output logic              o_q
);
    logic [REM_W:0]   w_sh;
    logic [REM_W-1:0] w_diff;

    assign w_sh   = {i_rem, i_bit};
    assign o_q    = (w_sh >= {2'b00, i_div});
    assign w_diff = w_sh[REM_W-1:0] - {1'b0, i_div};
    assign o_rem  = o_q ? w_diff : w_sh[REM_W-1:0];
endmodule

// File: rtl/myproject_sdiv_20s_8s_12_seq.sv
// Sequential signed divider: 20s / 8s -> 12s quotient, 8s remainder.
// Magnitudes are divided over 20 restoring steps, then signed and saturated.
module myproject_sdiv_20s_8s_12_seq
    import myproject_sdiv_pkg::*;
(
    input  logic ap_clk,
    input  logic ap_rst,
    myproject_sdiv_20s_8s_12_seq_if.slave bus
);
    state_t r_state;
    state_t w_next;

    logic [DIN0_W-1:0]        r_dvd;
    logic [DIN1_W-1:0]        r_dvs;
    logic [REM_W-1:0]         r_prem;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_sign_q;
    logic                     r_sign_r;
    logic signed [DOUT_W-1:0] r_dout;
    logic signed [DIN1_W-1:0] r_rem;
    logic                     r_ovf;
    logic                     r_dbz;

    logic                     w_accept;
    logic [DIN0_W-1:0]        w_abs0;
    logic [DIN1_W-1:0]        w_abs1;
    logic [REM_W-1:0]         w_prem;
    logic                     w_qbit;
    logic signed [DOUT_W-1:0] w_dout;
    logic signed [DIN1_W-1:0] w_rem;
    logic                     w_ovf;
    logic                     w_dbz;

    assign w_accept = bus.ap_start &&
                      (r_state == S_IDLE || r_state == S_DONE);

    assign w_abs0 = bus.din0[DIN0_W-1] ? (~bus.din0 + 20'd1) : bus.din0;
    assign w_abs1 = bus.din1[DIN1_W-1] ? (~bus.din1 + 8'd1) : bus.din1;

    myproject_sdiv_step u_step (
        .i_rem (r_prem),
        .i_div (r_dvs),
        .i_bit (r_dvd[DIN0_W-1]),
        .o_rem (w_prem),
        .o_q   (w_qbit)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.ap_start) w_next = S_CALC;
            S_CALC:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = bus.ap_start ? S_CALC : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Quotient magnitude is in r_dvd, remainder magnitude in r_prem
    always_comb begin
        w_dout = '0;
        w_rem  = '0;
        w_ovf  = 1'b0;
        w_dbz  = 1'b0;
        if (r_dvs == '0) begin
            w_dout = r_sign_r ? Q_MIN : Q_MAX;
            w_dbz  = 1'b1;
        end else begin
            w_rem = r_sign_r ? (~r_prem[DIN1_W-1:0] + 8'd1)
                             : r_prem[DIN1_W-1:0];
            if (r_sign_q) begin
                if (r_dvd > 20'd2048) begin
                    w_dout = Q_MIN;
                    w_ovf  = 1'b1;
                end else begin
                    w_dout = ~r_dvd[DOUT_W-1:0] + 12'd1;
                end
            end else begin
                if (r_dvd > 20'd2047) begin
                    w_dout = Q_MAX;
                    w_ovf  = 1'b1;
                end else begin
                    w_dout = r_dvd[DOUT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_prem   <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dout   <= '0;
            r_rem    <= '0;
            r_ovf    <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (w_accept) begin
            r_sign_q <= bus.din0[DIN0_W-1] ^ bus.din1[DIN1_W-1];
            r_sign_r <= bus.din0[DIN0_W-1];
            r_dvd    <= w_abs0;
            r_dvs    <= w_abs1;
            r_prem   <= '0;
            r_cnt    <= CNT_W'(ITERS - 1);
        end else if (r_state == S_CALC) begin
            r_prem <= w_prem;
            r_dvd  <= {r_dvd[DIN0_W-2:0], w_qbit};
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end else if (r_state == S_FIX) begin
            r_dout <= w_dout;
            r_rem  <= w_rem;
            r_ovf  <= w_ovf;
            r_dbz  <= w_dbz;
        end
    end

    assign bus.ap_idle  = (r_state == S_IDLE);
    assign bus.ap_done  = (r_state == S_DONE);
    assign bus.ap_ready = (r_state == S_DONE);
    assign bus.dout     = r_dout;
    assign bus.rem      = r_rem;
    assign bus.ovf      = r_ovf;
    assign bus.dbz      = r_dbz;
endmodule

// File: tb/tb_myproject_sdiv_20s_8s_12_seq.sv
// Self-checking bench for the sequential signed divider.
// Expected results are queued at stimulus time and popped at ap_done.
module tb_myproject_sdiv_20s_8s_12_seq;
    typedef struct packed {
        logic signed [11:0] q;
        logic signed [7:0]  r;
        logic               ovf;
        logic               dbz;
    } res_t;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    int   total  = 0;
    int   bad    = 0;
    res_t sb[$];

    myproject_sdiv_20s_8s_12_seq_if bus ();

    myproject_sdiv_20s_8s_12_seq dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic res_t model(int a, int b);
        res_t e;
        int   q;
        e = '0;
        if (b == 0) begin
            e.q   = (a >= 0) ? 12'sd2047 : -12'sd2048;
            e.dbz = 1'b1;
        end else begin
            q   = a / b;
            e.r = 8'(a % b);
            if (q > 2047) begin
                e.q = 12'sd2047; e.ovf = 1'b1;
            end else if (q < -2048) begin
                e.q = -12'sd2048; e.ovf = 1'b1;
            end else begin
                e.q = 12'(q);
            end
        end
        return e;
    endfunction

    function automatic res_t observe();
        return {bus.dout, bus.rem, bus.ovf, bus.dbz};
    endfunction

    // Issue one op from IDLE; lat counts negedges after accept (-1 on timeout)
    task automatic run_op(input int a, input int b,
                          output int lat, output res_t got);
        @(negedge ap_clk);
        bus.din0 = 20'(a);
        bus.din1 = 8'(b);
        bus.ap_start = 1'b1;
        sb.push_back(model(a, b));
        @(negedge ap_clk);
        bus.ap_start = 1'b0;
        bus.din0 = 20'h5A5A5;
        bus.din1 = 8'h55;
        lat = 1;
        while (bus.ap_done !== 1'b1 && lat < 40) begin
            @(negedge ap_clk);
            lat++;
        end
        if (bus.ap_done !== 1'b1) lat = -1;
        got = observe();
    endtask

    task automatic test_reset;
        @(negedge ap_clk);
        @(negedge ap_clk);
        total++;
        if ({bus.ap_idle, bus.ap_done, bus.ap_ready, observe()} !==
            {3'b100, 22'd0}) begin
            bad++;
            $display("FAIL reset: idle=%0b done=%0b rdy=%0b q=%0d r=%0d ovf=%0b dbz=%0b want 1/0/0/0/0/0/0",
                     bus.ap_idle, bus.ap_done, bus.ap_ready,
                     bus.dout, bus.rem, bus.ovf, bus.dbz);
        end
        ap_rst = 1'b0;
    endtask

    task automatic test_basic;
        int   lat;
        res_t got, exp;
        @(negedge ap_clk);
        bus.din0 = 20'sd1000;
        bus.din1 = 8'sd7;
        bus.ap_start = 1'b1;
        sb.push_back(model(1000, 7));
        @(negedge ap_clk);
        bus.ap_start = 1'b0;
        bus.din0 = 20'h12345;
        total++;
        if (bus.ap_idle !== 1'b0) begin
            bad++;
            $display("FAIL idle_drop: got %0b want 0", bus.ap_idle);
        end
        lat = 1;
        while (bus.ap_done !== 1'b1 && lat < 40) begin
            @(negedge ap_clk);
            lat++;
        end
        if (bus.ap_done !== 1'b1) lat = -1;
        got = observe();
        exp = sb.pop_front();
        total++;
        if (lat != 22) begin
            bad++;
            $display("FAIL basic_lat: got %0d want 22", lat);
        end
        total++;
        if (got !== exp || exp.q != 142 || exp.r != 6) begin
            bad++;
            $display("FAIL basic: got q=%0d r=%0d ovf=%0b dbz=%0b want q=142 r=6 ovf=0 dbz=0",
                     got.q, got.r, got.ovf, got.dbz);
        end
        @(negedge ap_clk);
        total++;
        if ({bus.ap_done, bus.ap_idle} !== 2'b01) begin
            bad++;
            $display("FAIL done_pulse: done=%0b idle=%0b want 0/1",
                     bus.ap_done, bus.ap_idle);
        end
    endtask

    task automatic test_vectors(input string name, input int a[4],
                                input int b[4], input int n);
        int   lat;
        res_t got, exp;
        for (int i = 0; i < n; i++) begin
            run_op(a[i], b[i], lat, got);
            exp = sb.pop_front();
            total++;
            if (lat != 22) begin
                bad++;
                $display("FAIL %s_lat[%0d]: got %0d want 22", name, i, lat);
            end
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s[%0d] %0d/%0d: got q=%0d r=%0d ovf=%0b dbz=%0b want q=%0d r=%0d ovf=%0b dbz=%0b",
                         name, i, a[i], b[i], got.q, got.r, got.ovf, got.dbz,
                         exp.q, exp.r, exp.ovf, exp.dbz);
            end
        end
    endtask

    task automatic test_signs;
        test_vectors("sign", '{-1000, 1000, -1000, 0},
                     '{7, -7, -7, 1}, 3);
    endtask

    task automatic test_saturation;
        test_vectors("sat", '{-524288, -524288, 2048, -2048},
                     '{-1, 1, 1, 1}, 4);
    endtask

    task automatic test_div_zero;
        test_vectors("dbz", '{5, -5, 0, 0}, '{0, 0, 0, 0}, 2);
    endtask

    task automatic test_back_to_back;
        int   a[4] = '{1000, -777, 524287, -300};
        int   b[4] = '{7, -3, 100, 0};
        int   lat;
        res_t got, exp;
        @(negedge ap_clk);
        bus.din0 = 20'(a[0]);
        bus.din1 = 8'(b[0]);
        bus.ap_start = 1'b1;
        sb.push_back(model(a[0], b[0]));
        for (int i = 0; i < 4; i++) begin
            lat = 0;
            do begin
                @(negedge ap_clk);
                lat++;
            end while (bus.ap_done !== 1'b1 && lat < 40);
            if (bus.ap_done !== 1'b1) lat = -1;
            got = observe();
            exp = sb.pop_front();
            total++;
            if (lat != 22) begin
                bad++;
                $display("FAIL b2b_lat[%0d]: got %0d want 22", i, lat);
            end
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL b2b[%0d]: got q=%0d r=%0d ovf=%0b dbz=%0b want q=%0d r=%0d ovf=%0b dbz=%0b",
                         i, got.q, got.r, got.ovf, got.dbz,
                         exp.q, exp.r, exp.ovf, exp.dbz);
            end
            if (i < 3) begin
                bus.din0 = 20'(a[i+1]);
                bus.din1 = 8'(b[i+1]);
                sb.push_back(model(a[i+1], b[i+1]));
            end else begin
                bus.ap_start = 1'b0;
            end
        end
        @(negedge ap_clk);
        total++;
        if (bus.ap_idle !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle: got %0b want 1", bus.ap_idle);
        end
    endtask

    task automatic test_ignore_start;
        int   lat;
        res_t got, exp;
        @(negedge ap_clk);
        bus.din0 = 20'sd1000;
        bus.din1 = 8'sd7;
        bus.ap_start = 1'b1;
        sb.push_back(model(1000, 7));
        @(negedge ap_clk);
        bus.ap_start = 1'b0;
        lat = 1;
        while (bus.ap_done !== 1'b1 && lat < 40) begin
            @(negedge ap_clk);
            lat++;
            if (lat == 5) begin
                bus.ap_start = 1'b1;
                bus.din0 = 20'sd1;
                bus.din1 = 8'sd1;
            end
            if (lat == 6) bus.ap_start = 1'b0;
        end
        if (bus.ap_done !== 1'b1) lat = -1;
        got = observe();
        exp = sb.pop_front();
        total++;
        if (lat != 22) begin
            bad++;
            $display("FAIL ignore_lat: got %0d want 22", lat);
        end
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL ignore: got q=%0d r=%0d want q=%0d r=%0d",
                     got.q, got.r, exp.q, exp.r);
        end
        @(negedge ap_clk);
        total++;
        if ({bus.ap_done, bus.ap_idle} !== 2'b01) begin
            bad++;
            $display("FAIL ignore_noqueue: done=%0b idle=%0b want 0/1",
                     bus.ap_done, bus.ap_idle);
        end
    endtask

    task automatic test_reset_midop;
        int   lat;
        res_t got, exp;
        run_op(-1000, 7, lat, got);
        void'(sb.pop_front());
        @(negedge ap_clk);
        bus.din0 = 20'sd1000;
        bus.din1 = 8'sd7;
        bus.ap_start = 1'b1;
        sb.push_back(model(1000, 7));
        @(negedge ap_clk);
        bus.ap_start = 1'b0;
        repeat (9) @(negedge ap_clk);
        ap_rst = 1'b1;
        #1;
        void'(sb.pop_front());
        total++;
        if ({bus.ap_idle, bus.ap_done, bus.ap_ready, observe()} !==
            {3'b100, 22'd0}) begin
            bad++;
            $display("FAIL midop_rst: idle=%0b done=%0b q=%0d r=%0d ovf=%0b dbz=%0b want 1/0/0/0/0/0",
                     bus.ap_idle, bus.ap_done, bus.dout, bus.rem,
                     bus.ovf, bus.dbz);
        end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        run_op(100, -3, lat, got);
        exp = sb.pop_front();
        total++;
        if (lat != 22 || got !== exp || exp.q != -33 || exp.r != 1) begin
            bad++;
            $display("FAIL post_rst: lat=%0d q=%0d r=%0d want lat=22 q=-33 r=1",
                     lat, got.q, got.r);
        end
    endtask

    initial begin
        bus.ap_start = 1'b0;
        bus.din0 = '0;
        bus.din1 = '0;
        test_reset();
        test_basic();
        test_signs();
        test_saturation();
        test_div_zero();
        test_back_to_back();
        test_ignore_start();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
